// File: rtl/vpg_timing_pkg.sv
// vpg_timing_pkg: mode codes, timing record and per-mode constant table for
// the video pattern generator. All values are zero-based counter terminals.
package vpg_timing_pkg;

    localparam logic [3:0] MODE_800X600  = 4'd0;
    localparam logic [3:0] MODE_640X480  = 4'd1;
    localparam logic [3:0] MODE_1024X768 = 4'd2;
    localparam logic [3:0] MODE_1280X720 = 4'd3;

    typedef struct packed {
        logic [11:0] h_total;
        logic [11:0] h_sync;
        logic [11:0] h_start;
        logic [11:0] h_end;
        logic [11:0] v_total;
        logic [11:0] v_sync;
        logic [11:0] v_start;
        logic [11:0] v_end;
    } vpg_timing_t;

    // Unknown codes fall back to the 640x480 entry, which every monitor accepts.
    function automatic vpg_timing_t timing_lookup(input logic [3:0] mode);
        vpg_timing_t t;
        case (mode)
            MODE_800X600:  t = '{12'd1055, 12'd127, 12'd212, 12'd1012,
                                12'd627,  12'd3,   12'd26,  12'd626};
            MODE_1024X768: t = '{12'd1343, 12'd135, 12'd292, 12'd1316,
                                12'd805,  12'd5,   12'd34,  12'd802};
            MODE_1280X720: t = '{12'd1649, 12'd39,  12'd256, 12'd1536,
                                12'd749,  12'd4,   12'd24,  12'd744};
            default:       t = '{12'd799,  12'd95,  12'd141, 12'd781,
                                12'd524,  12'd1,   12'd34,  12'd514};
        endcase
        return t;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/vpg_lock_sync.sv
// vpg_lock_sync: 2-FF synchroniser for the asynchronous PLL lock plus a
// consecutive-lock counter; o_stable marks the LOCK_STABLE-th locked cycle.
module vpg_lock_sync #(
    parameter int unsigned LOCK_STABLE = 4096
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_lock_async,
    input  logic i_enable,
    output logic o_lock_sync,
    output logic o_stable
);

    localparam int unsigned     CW   = (LOCK_STABLE > 2) ? $clog2(LOCK_STABLE) : 1;
    localparam logic [CW-1:0]   LAST = CW'(LOCK_STABLE - 1);

    logic          r_meta;
    logic          r_sync;
    logic [CW-1:0] r_cnt;

    // Two-flop synchroniser for the lock input.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_lock_async;
            r_sync <= r_meta;
        end
    end

    // Consecutive-lock counter: clears on lock loss or when disabled, saturates at LAST.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_enable || !r_sync) begin
            r_cnt <= '0;
        end else if (r_cnt != LAST) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_lock_sync = r_sync;
    assign o_stable    = r_sync && (r_cnt == LAST);

endmodule

// File: rtl/vpg_mode_sequencer.sv
// vpg_mode_sequencer: blanks the generator, reprograms the pixel PLL, waits
// for stable lock, loads the new mode's timings and releases the generator.
// Optional feature macro: VPG_LOCK_TIMEOUT_EN (WAIT_LOCK watchdog + lock_err).
module vpg_mode_sequencer #(
    parameter logic [3:0]  DEFAULT_MODE = 4'd0,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned UNLOCK_WAIT  = 1024,
    parameter int unsigned LOCK_STABLE  = 4096,
    parameter int unsigned LOCK_TIMEOUT = 2500000
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic [3:0]  mode_req,
    input  logic        mode_req_valid,
    output logic        mode_req_ready,
    input  logic        pll_locked,
    output logic [3:0]  pll_mode,
    output logic        pll_mode_change,
    output logic        gen_reset,
    output logic [11:0] h_total,
    output logic [11:0] h_sync,
    output logic [11:0] h_start,
    output logic [11:0] h_end,
    output logic [11:0] v_total,
    output logic [11:0] v_sync,
    output logic [11:0] v_start,
    output logic [11:0] v_end,
    output logic [3:0]  active_mode,
    output logic        lock_err
);
    import vpg_timing_pkg::*;

    localparam logic [1:0] ST_BLANK  = 2'd0;
    localparam logic [1:0] ST_RECONF = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    localparam int unsigned   CNT_MAX      = max3(BLANK_CYCLES, UNLOCK_WAIT, LOCK_TIMEOUT);
    localparam int unsigned   CNT_W        = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] UNLOCK_LAST = CNT_W'(UNLOCK_WAIT - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_target;
    logic [3:0]       r_pll_mode;
    logic             r_pll_change;
    logic             r_gen_reset;
    logic [3:0]       r_active;
    vpg_timing_t      r_timing;

    logic             w_lock_sync;
    logic             w_stable;
    logic             w_accept;
    logic             w_wd_expire;

    vpg_lock_sync #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock_sync (
        .i_clk        (clk_50),
        .i_rst        (reset),
        .i_lock_async (pll_locked),
        .i_enable     (r_state == ST_WAIT),
        .o_lock_sync  (w_lock_sync),
        .o_stable     (w_stable)
    );

    assign w_accept = mode_req_valid && (r_state == ST_RUN);

`ifdef VPG_LOCK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    logic r_lock_err;

    // r_cnt doubles as the watchdog in WAIT_LOCK; it is zero on every entry.
    assign w_wd_expire = (r_state == ST_WAIT) && !w_stable && (r_cnt == TIMEOUT_LAST);

    // Sticky lock-timeout flag, cleared only by reset.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_lock_err <= 1'b0;
        end else if (w_wd_expire) begin
            r_lock_err <= 1'b1;
        end
    end

    assign lock_err = r_lock_err;
`else
    assign w_wd_expire = 1'b0;
    assign lock_err    = 1'b0;
`endif

    // Mode-change sequencer FSM with PLL handshake and timing registers.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_state      <= ST_BLANK;
            r_cnt        <= '0;
            r_target     <= DEFAULT_MODE;
            r_pll_mode   <= DEFAULT_MODE;
            r_pll_change <= 1'b0;
            r_gen_reset  <= 1'b1;
            r_active     <= DEFAULT_MODE;
            r_timing     <= timing_lookup(DEFAULT_MODE);
        end else begin
            r_pll_change <= 1'b0;
            case (r_state)
                ST_BLANK: begin
                    r_gen_reset <= 1'b1;
                    if (r_cnt == BLANK_LAST) begin
                        r_pll_mode   <= r_target;
                        r_pll_change <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= ST_RECONF;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RECONF: begin
                    if (r_cnt == UNLOCK_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (w_stable) begin
                        r_timing <= timing_lookup(r_target);
                        r_active <= r_target;
                        r_cnt    <= '0;
                        r_state  <= ST_RUN;
                    end else if (w_wd_expire) begin
                        r_cnt   <= '0;
                        r_state <= ST_BLANK;
                    end else begin
`ifdef VPG_LOCK_TIMEOUT_EN
                        r_cnt <= r_cnt + 1'b1;
`else
                        r_cnt <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    // Release lags the timing load by one cycle; a request beats lock loss.
                    r_gen_reset <= 1'b0;
                    if (w_accept && (mode_req != r_active)) begin
                        r_target    <= mode_req;
                        r_gen_reset <= 1'b1;
                        r_state     <= ST_BLANK;
                    end else if (!w_lock_sync) begin
                        r_gen_reset <= 1'b1;
                        r_state     <= ST_WAIT;
                    end
                end
                default: begin
                    r_state <= ST_BLANK;
                end
            endcase
        end
    end

    assign mode_req_ready  = (r_state == ST_RUN);
    assign pll_mode        = r_pll_mode;
    assign pll_mode_change = r_pll_change;
    assign gen_reset       = r_gen_reset;
    assign active_mode     = r_active;
    assign h_total         = r_timing.h_total;
    assign h_sync          = r_timing.h_sync;
    assign h_start         = r_timing.h_start;
    assign h_end           = r_timing.h_end;
    assign v_total         = r_timing.v_total;
    assign v_sync          = r_timing.v_sync;
    assign v_start         = r_timing.v_start;
    assign v_end           = r_timing.v_end;

endmodule

// File: tb/tb_vpg_mode_sequencer.sv
// Testbench for vpg_mode_sequencer: behavioural reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_vpg_mode_sequencer;
    import vpg_timing_pkg::*;

    localparam int unsigned BLANK_CYCLES = 4;
    localparam int unsigned UNLOCK_WAIT  = 8;
    localparam int unsigned LOCK_STABLE  = 16;
    localparam int unsigned LOCK_TIMEOUT = 200;
`ifdef VPG_LOCK_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  mode_req = 4'd0;
    logic        mode_req_valid = 1'b0;
    logic        mode_req_ready;
    logic        pll_locked = 1'b1;
    logic [3:0]  pll_mode;
    logic        pll_mode_change;
    logic        gen_reset;
    logic [11:0] h_total, h_sync, h_start, h_end;
    logic [11:0] v_total, v_sync, v_start, v_end;
    logic [3:0]  active_mode;
    logic        lock_err;

    vpg_mode_sequencer #(
        .DEFAULT_MODE (4'd0),
        .BLANK_CYCLES (BLANK_CYCLES),
        .UNLOCK_WAIT  (UNLOCK_WAIT),
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk_50          (clk),
        .reset           (reset),
        .mode_req        (mode_req),
        .mode_req_valid  (mode_req_valid),
        .mode_req_ready  (mode_req_ready),
        .pll_locked      (pll_locked),
        .pll_mode        (pll_mode),
        .pll_mode_change (pll_mode_change),
        .gen_reset       (gen_reset),
        .h_total         (h_total),
        .h_sync          (h_sync),
        .h_start         (h_start),
        .h_end           (h_end),
        .v_total         (v_total),
        .v_sync          (v_sync),
        .v_start         (v_start),
        .v_end           (v_end),
        .active_mode     (active_mode),
        .lock_err        (lock_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pmc_total = 0;

    // Reference model: phase, cycles spent in phase, consecutive locked cycles.
    typedef enum {P_BLANK, P_RECONF, P_WAIT, P_RUN} phase_e;
    phase_e      m_phase;
    int          m_elapsed;
    int          m_run;
    logic [3:0]  m_target, m_pll_mode, m_active;
    logic        m_pmc, m_gen, m_lock_err;
    logic        m_s1, m_s2;
    vpg_timing_t m_tim;

    function automatic vpg_timing_t ref_timing(input logic [3:0] mode);
        vpg_timing_t t;
        case (mode)
            4'd0:    t = '{12'd1055, 12'd127, 12'd212, 12'd1012, 12'd627, 12'd3, 12'd26, 12'd626};
            4'd2:    t = '{12'd1343, 12'd135, 12'd292, 12'd1316, 12'd805, 12'd5, 12'd34, 12'd802};
            4'd3:    t = '{12'd1649, 12'd39,  12'd256, 12'd1536, 12'd749, 12'd4, 12'd24, 12'd744};
            default: t = '{12'd799,  12'd95,  12'd141, 12'd781,  12'd524, 12'd1, 12'd34, 12'd514};
        endcase
        return t;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_BLANK; m_elapsed = 0; m_run = 0;
        m_target = 4'd0; m_pll_mode = 4'd0; m_active = 4'd0;
        m_pmc = 1'b0; m_gen = 1'b1; m_lock_err = 1'b0;
        m_s1 = 1'b0; m_s2 = 1'b0;
        m_tim = ref_timing(4'd0);
    endtask

    task automatic model_edge();
        logic old_sync;
        logic acc;
        old_sync = m_s2;
        m_s2 = m_s1;
        m_s1 = pll_locked;
        acc = mode_req_valid && (m_phase == P_RUN);
        m_pmc = 1'b0;
        case (m_phase)
            P_BLANK: begin
                m_elapsed++;
                if (m_elapsed == BLANK_CYCLES) begin
                    m_pll_mode = m_target; m_pmc = 1'b1;
                    m_phase = P_RECONF; m_elapsed = 0;
                end
            end
            P_RECONF: begin
                m_elapsed++;
                if (m_elapsed == UNLOCK_WAIT) begin
                    m_phase = P_WAIT; m_elapsed = 0; m_run = 0;
                end
            end
            P_WAIT: begin
                m_run = old_sync ? m_run + 1 : 0;
                if (m_run == LOCK_STABLE) begin
                    m_tim = ref_timing(m_target); m_active = m_target; m_phase = P_RUN;
                end else if (TIMEOUT_EN) begin
                    m_elapsed++;
                    if (m_elapsed == LOCK_TIMEOUT) begin
                        m_lock_err = 1'b1; m_phase = P_BLANK; m_elapsed = 0;
                    end
                end
            end
            P_RUN: begin
                if (acc && (mode_req != m_active)) begin
                    m_target = mode_req; m_gen = 1'b1; m_phase = P_BLANK; m_elapsed = 0;
                end else if (!old_sync) begin
                    m_gen = 1'b1; m_phase = P_WAIT; m_elapsed = 0; m_run = 0;
                end else begin
                    m_gen = 1'b0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        chk("gen_reset",       gen_reset,       m_gen);
        chk("pll_mode_change", pll_mode_change, m_pmc);
        chk("pll_mode",        pll_mode,        m_pll_mode);
        chk("mode_req_ready",  mode_req_ready,  m_phase == P_RUN);
        chk("active_mode",     active_mode,     m_active);
        chk("lock_err",        lock_err,        m_lock_err);
        chk("timings", {h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end}, m_tim);
    endtask

    // One clock: advance the model at the edge, compare 1 ns later.
    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        #1;
        compare_all();
        if (pll_mode_change === 1'b1) pmc_total++;
    endtask

    task automatic wait_pmc(input int limit, output int n);
        n = 0;
        do begin step(); n++; end while (pll_mode_change !== 1'b1 && n < limit);
        if (pll_mode_change !== 1'b1) begin
            checks++; errors++;
            $display("FAIL wait_pmc: no pll_mode_change within %0d cycles", limit);
        end
    endtask

    task automatic wait_gen(input logic val, input int limit, output int n);
        n = 0;
        do begin step(); n++; end while (gen_reset !== val && n < limit);
        if (gen_reset !== val) begin
            checks++; errors++;
            $display("FAIL wait_gen: gen_reset not %0b within %0d cycles", val, limit);
        end
    endtask

    task automatic request(input logic [3:0] m);
        mode_req = m; mode_req_valid = 1'b1;
        step();
        mode_req_valid = 1'b0;
    endtask

    initial begin
        int n;
        int p0;
        int glitch;
        model_reset();

        // Reset values.
        step(); step();
        chk("rst_gen_reset", gen_reset, 1'b1);
        chk("rst_pmc", pll_mode_change, 1'b0);
        chk("rst_ready", mode_req_ready, 1'b0);
        chk("rst_lock_err", lock_err, 1'b0);
        chk("rst_h_total", h_total, 12'd1055);

        // 1: bring-up with lock held.
        reset = 1'b0;
        wait_pmc(50, n);
        chk("t1_pmc_latency", n, 4);
        chk("t1_pll_mode", pll_mode, 4'd0);
        wait_gen(1'b0, 100, n);
        chk("t1_release_latency", n, 25);

        // 2: switch to 640x480.
        request(4'd1);
        chk("t2_ready_drop", mode_req_ready, 1'b0);
        chk("t2_gen_high", gen_reset, 1'b1);
        wait_pmc(50, n);
        chk("t2_pll_mode", pll_mode, 4'd1);
        wait_gen(1'b0, 100, n);
        chk("t2_release_latency", n, 25);
        chk("t2_h_total", h_total, 12'd799);
        chk("t2_h_start", h_start, 12'd141);
        chk("t2_v_total", v_total, 12'd524);
        chk("t2_v_end", v_end, 12'd514);

        // 3: request the mode already active.
        p0 = pmc_total;
        request(4'd1);
        for (int i = 0; i < 10; i++) step();
        chk("t3_no_pmc", pmc_total - p0, 0);
        chk("t3_gen_low", gen_reset, 1'b0);
        chk("t3_ready", mode_req_ready, 1'b1);

        // 4: one-cycle lock glitch in WAIT_LOCK.
        request(4'd2);
        wait_pmc(50, n);
        for (int i = 0; i < 13; i++) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        wait_gen(1'b0, 100, n);
        chk("t4_release_after_glitch", n, 19);
        chk("t4_active", active_mode, 4'd2);

        // 5: lock loss in RUN.
        p0 = pmc_total;
        pll_locked = 1'b0;
        wait_gen(1'b1, 10, n);
        chk("t5_gen_latency", n, 3);
        for (int i = 0; i < 5; i++) step();
        pll_locked = 1'b1;
        wait_gen(1'b0, 100, n);
        chk("t5_relock_latency", n, 19);
        chk("t5_no_pmc", pmc_total - p0, 0);

        // 6: timeout retry (feature build), then async reset mid-RECONF.
`ifdef VPG_LOCK_TIMEOUT_EN
        mode_req = 4'd3; mode_req_valid = 1'b1; pll_locked = 1'b0;
        step();
        mode_req_valid = 1'b0;
        wait_pmc(50, n);
        n = 0;
        do begin step(); n++; end while (lock_err !== 1'b1 && n < 400);
        chk("t6_timeout_latency", n, 208);
        wait_pmc(50, n);
        chk("t6_retry_latency", n, 4);
        chk("t6_retry_mode", pll_mode, 4'd3);
`else
        request(4'd3);
        wait_pmc(50, n);
`endif
        for (int i = 0; i < 3; i++) step();
        #3 reset = 1'b1;
        #1;
        chk("t6_async_gen", gen_reset, 1'b1);
        chk("t6_async_lock_err", lock_err, 1'b0);
        chk("t6_async_active", active_mode, 4'd0);
        model_reset();
        step(); step();
        reset = 1'b0;
        pll_locked = 1'b1;
        wait_pmc(50, n);
        chk("t6_restart_latency", n, 4);
        chk("t6_restart_mode", pll_mode, 4'd0);

        // Random traffic: strobes in any state, occasional lock dropouts.
        glitch = 0;
        for (int i = 0; i < 3000; i++) begin
            mode_req_valid = ($urandom_range(0, 9) == 0);
            mode_req = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                   : 4'($urandom_range(0, 5));
            if (glitch > 0) begin
                glitch--;
                pll_locked = 1'b0;
            end else begin
                pll_locked = 1'b1;
                if ($urandom_range(0, 249) == 0) glitch = $urandom_range(1, 4);
            end
            step();
        end
        mode_req_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
